cla_adder_pipe: RTL

//   Parametrised, carry-pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit CLA.

---
 rtl/cla_adder_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Carry-pipelined carry-lookahead adder/subtractor: one 4-bit CLA group resolved per stage.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf_out.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C0_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out
`ifdef CLA_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned NGRP = WIDTH / 4;

  logic advance;

  // Whole pipeline moves as one; bubbles are kept so latency is fixed.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // sa holds {resolved sum bits, unresolved A bits}; each stage shifts one group of sum in at
  // the top, so the current A group is always sa[3:0] and the final stage holds S in order.
  for (genvar k = 0; k <= NGRP; k++) begin : g_stg
    logic             vld;
    logic             cy;
    logic [WIDTH-1:0] sa;

    // Unresolved B' bits only; shrinks by one group per stage.
    if (k < NGRP) begin : g_b
      logic [WIDTH-4*k-1:0] b;
    end

    if (k == 0) begin : g_in
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld             <= 1'b0;
          cy              <= 1'b0;
          sa              <= '0;
          g_stg[0].g_b.b  <= '0;
        end else if (advance) begin
          vld             <= in_valid;
          cy              <= sub_in ^ C0_in;
          sa              <= A_in;
          g_stg[0].g_b.b  <= sub_in ? ~B_in : B_in;
        end
      end
    end else begin : g_cla
      logic [4:0] res;

      assign res = cla4(g_stg[k-1].sa[3:0], g_stg[k-1].g_b.b[3:0], g_stg[k-1].cy);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= 1'b0;
          cy  <= 1'b0;
          sa  <= '0;
        end else if (advance) begin
          vld <= g_stg[k-1].vld;
          cy  <= res[4];
          sa  <= WIDTH'({res[3:0], g_stg[k-1].sa} >> 4);
        end
      end

      if (k < NGRP) begin : g_fwd
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            g_stg[k].g_b.b <= '0;
          end else if (advance) begin
            g_stg[k].g_b.b <= g_stg[k-1].g_b.b[WIDTH-4*k+3:4];
          end
        end
      end

`ifdef CLA_OVF_EN
      // The operand MSBs are last visible in the MSB group, so overflow is formed here.
      if (k == NGRP) begin : g_ovf
        logic ovf;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf <= 1'b0;
          end else if (advance) begin
            ovf <= (g_stg[k-1].sa[3] == g_stg[k-1].g_b.b[3]) && (res[3] != g_stg[k-1].sa[3]);
          end
        end
      end
`endif
    end
  end

  // Output register: holds the result steady while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      S_out     <= '0;
      C_out     <= 1'b0;
`ifdef CLA_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else if (advance) begin
      out_valid <= g_stg[NGRP].vld;
      S_out     <= g_stg[NGRP].sa;
      C_out     <= g_stg[NGRP].cy;
`ifdef CLA_OVF_EN
      ovf_out   <= g_stg[NGRP].g_cla.g_ovf.ovf;
`endif
    end
  end

endmodule
